shared_reg_arbiter: RTL
=======================

// Module: shared_reg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit DFF register among NUM_REQ requesters.
//  Each cycle it picks at most one requester, loads that requester's data into the
//  shared register and returns a one-cycle grant pulse.
//  Sits between the register-bank clients and the storage flops, so no requester writes
//  the flops directly.
// PARAMETERS
//  NUM_REQ   4   number of requesters, >=2
//  WIDTH     8   shared register width, bits
//  MAX_LOCK  16  max consecutive lock re-grants, >=1 (used only with SHARED_REG_LOCK_EN)
// PORTS
//  clk      in   1                clock; all state updates on rising edge
//  reset    in   1                synchronous, active-high reset
//  req      in   NUM_REQ          per-requester write request, level, held until granted
//  wdata    in   NUM_REQ*WIDTH    lane i = wdata[i*WIDTH +: WIDTH]
//  lock     in   NUM_REQ          request to keep ownership; port always present
//  gnt      out  NUM_REQ          one-hot grant pulse, registered
//  q        out  WIDTH            shared register contents
//  q_valid  out  1                sticky; 1 once any write has occurred since reset
//  owner    out  $clog2(NUM_REQ)  index of last granted requester
// BEHAVIOUR
//  - Reset (sync, highest priority), visible after the edge:
//    gnt=0, q=0, q_valid=0, owner=0, rr pointer ptr=0, lock count cnt=0, state=IDLE.
//  - FSM states: IDLE (no grant outstanding), GRANT (gnt pulse high this cycle),
//    LOCK (owner holds exclusive access; macro only).
//  - Arbitration at edge k uses req sampled at edge k.
//    Winner = first set bit of the eligible req, searching ptr, ptr+1, ... NUM_REQ-1, 0, ...
//  - Result of a win at edge k: gnt[winner]=1, q<=wdata lane winner, owner<=winner,
//    q_valid<=1, ptr<=winner+1 (wraps NUM_REQ-1 -> 0), state<=GRANT.
//    All of these are visible the cycle after edge k; latency is 1 cycle.
//  - No eligible req at edge k: gnt=0, q/owner/ptr hold, state<=IDLE.
//  - In GRANT, the current owner is masked from eligibility for that edge.
//    - A single requester holding req is granted every other cycle.
//    - Different requesters can be granted back-to-back.
//  - Requester must drop req in the cycle its gnt is high if it has no further write.
//    A req still high at the next eligible edge is a new request.
//  - Exactly one gnt bit is high, or none. q changes only on a grant.
//  - Simultaneous req from all lanes: strict rotation, no starvation.
//    Worst-case wait is NUM_REQ-1 grants (excluding lock).
// CONFIGURATION
//  SHARED_REG_LOCK_EN defined:
//  - Entering LOCK: a GRANT-state edge with lock[owner]=1 and req[owner]=1 re-grants owner
//    (no mask), sets cnt=1, state<=LOCK. ptr is not advanced on re-grants.
//  - LOCK edge, lock[owner]=0 or cnt==MAX_LOCK: normal arbitration with owner masked;
//    go to GRANT if there is a winner, else IDLE; cnt<=0.
//  - LOCK edge otherwise: if req[owner]=1, re-grant owner with gnt pulse and q update;
//    if req[owner]=0, no gnt. Either way cnt<=cnt+1 and state stays LOCK.
//  - Max consecutive grants to one owner = MAX_LOCK+1.
//  - Reset in LOCK: IDLE after the edge, same values as normal reset.
//  SHARED_REG_LOCK_EN undefined:
//  - lock input is ignored and the LOCK state and cnt are not built.
//  - Behaviour is identical to the defined case with lock tied to 0.
// TESTING
//  1 reset=1 two edges, req=0000 -> gnt=0000, q=0x00, q_valid=0, owner=0.
//  2 req=1111 held, lanes 0x11/0x22/0x33/0x44 -> gnt 0001,0010,0100,1000,0001
//    on consecutive cycles; q=0x11,0x22,0x33,0x44,0x11.
//  3 after owner=1 (ptr=2), req=0011 -> gnt=0001 (wrap-around), q=lane0 data.
//  4 req=0100 held alone -> gnt 0100,0000,0100,0000; q_valid=1 from first grant.
//  5 LOCK_EN, MAX_LOCK=4, req=0011, lock=0001 held, ptr=0 -> five consecutive gnt=0001,
//    then gnt=0010.
//  6 reset mid-LOCK -> next cycle gnt=0000, q=0x00, q_valid=0; then req=1111 -> gnt=0001.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Purpose : Bundles the requester-side bus of shared_reg_arbiter.
//           The requesters drive req/wdata/lock. The arbiter returns gnt, the shared
//           register contents q, the sticky q_valid flag and the owner index.
// Modports: master - requester side (drives req, wdata, lock)
//           slave  - arbiter side   (drives gnt, q, q_valid, owner)
// Params  : NUM_REQ requesters, WIDTH-bit shared register.
interface shared_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [OW-1:0]            owner;

  modport master (
    output req, wdata, lock,
    input  gnt, q, q_valid, owner
  );

  modport slave (
    input  req, wdata, lock,
    output gnt, q, q_valid, owner
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Purpose : Round-robin arbiter that owns one WIDTH-bit register shared by NUM_REQ
//           requesters. Each cycle it grants at most one requester. The winner's
//           wdata lane is loaded into q, and the winner gets a one-cycle gnt pulse.
// Ports   : clk     - clock, rising edge
//           reset   - synchronous, active-high
//           bus     - shared_reg_arbiter_if.slave
//                     (req, wdata, lock in; gnt, q, q_valid, owner out)
// Config  : define SHARED_REG_LOCK_EN to build the LOCK state. In LOCK, the owner keeps
//           re-grants for up to MAX_LOCK extra edges. Without the macro, lock is ignored.
//
// state | meaning
// IDLE  | no grant outstanding
// GRANT | gnt pulse high this cycle; owner masked at the next edge
// LOCK  | owner holds exclusive access (SHARED_REG_LOCK_EN only)
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic               clk,
  input  logic               reset,
  shared_reg_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("shared_reg_arbiter: NUM_REQ must be >= 2");
  end
  if (MAX_LOCK < 1) begin : g_bad_max_lock
    $error("shared_reg_arbiter: MAX_LOCK must be >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;

  logic [NUM_REQ-1:0]   mask;
  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] rot;
  logic                 found;
  logic [OW-1:0]        win;
  logic [WIDTH-1:0]     lane_win;
  logic [WIDTH-1:0]     lane_own;
  logic                 do_arb;
  int                   widx;

`ifdef SHARED_REG_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Rotate the eligible vector so that bit 0 is the requester at ptr.
  // The lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    mask     = '0;
    if (state_q == ST_GRANT || state_q == ST_LOCK) mask[owner_q] = 1'b1;
    eligible = bus.req & ~mask;
    rot      = {eligible, eligible} >> ptr_q;
    found    = 1'b0;
    win      = '0;
    widx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        widx  = int'(ptr_q) + i;
        if (widx >= NUM_REQ) widx = widx - NUM_REQ;
        win   = OW'(widx);
      end
    end
  end

  always_comb begin
    lane_win = '0;
    lane_own = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == win)     lane_win = bus.wdata[i*WIDTH +: WIDTH];
      if (OW'(i) == owner_q) lane_own = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = ST_IDLE;
    gnt_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    do_arb    = 1'b1;
`ifdef SHARED_REG_LOCK_EN
    cnt_d     = '0;
    // Lock re-grants leave ptr where it is, so rotation resumes fairly after the lock.
    if (state_q == ST_GRANT && bus.lock[owner_q] && bus.req[owner_q]) begin
      do_arb         = 1'b0;
      gnt_d[owner_q] = 1'b1;
      q_d            = lane_own;
      q_valid_d      = 1'b1;
      cnt_d          = CW'(1);
      state_d        = ST_LOCK;
    end else if (state_q == ST_LOCK && bus.lock[owner_q] &&
                 cnt_q != CW'(MAX_LOCK)) begin
      do_arb  = 1'b0;
      cnt_d   = cnt_q + CW'(1);
      state_d = ST_LOCK;
      if (bus.req[owner_q]) begin
        gnt_d[owner_q] = 1'b1;
        q_d            = lane_own;
        q_valid_d      = 1'b1;
      end
    end
`endif
    if (do_arb && found) begin
      gnt_d[win] = 1'b1;
      q_d        = lane_win;
      q_valid_d  = 1'b1;
      owner_d    = win;
      ptr_d      = (win == OW'(NUM_REQ - 1)) ? '0 : win + OW'(1);
      state_d    = ST_GRANT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
`ifdef SHARED_REG_LOCK_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
`ifdef SHARED_REG_LOCK_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.owner   = owner_q;
endmodule
